// File: rtl/sram_block_fetcher.sv
// Purpose: sole SRAM initiator. It streams a burst of consecutive entries to a
//          valid/ready consumer and slips single-entry writes into the idle bus cycles.
// Latency: read strobe in the cycle after start is sampled; data valid one cycle later.
//          Each entry takes at least 2 cycles.
// Backpressure: out_ready low holds HOLD with stable data. wr_req waits through READ
//          cycles and is acked combinationally in any other state.
// Ports: clk/rst; burst control (start, base_addr, count, busy, done);
//        stream out (out_data, out_valid, out_ready, out_last);
//        write request (wr_req, wr_addr, wr_data, wr_ack); SRAM strobe interface.
module sram_block_fetcher #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ack,
  output logic                 sram_read_enable,
  output logic                 sram_write_enable,
  output logic [ADDR_BITS-1:0] sram_address,
  output logic [DATA_BITS-1:0] sram_write_data,
  input  logic [DATA_BITS-1:0] sram_read_data
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  localparam logic [ADDR_BITS:0] REM_ONE = (ADDR_BITS+1)'(1);

  state_t                 state, state_nxt;
  logic [ADDR_BITS-1:0]   cur_addr, cur_addr_nxt;
  logic [ADDR_BITS:0]     remaining, remaining_nxt;
  logic [DATA_BITS-1:0]   out_data_nxt;
  logic                   out_valid_nxt, out_last_nxt;
  logic                   bus_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            cur_addr_nxt  = base_addr;
            remaining_nxt = count;
            state_nxt     = READ;
          end else begin
            // Empty burst still owes the requester a done pulse.
            state_nxt = DONE;
          end
        end
      end
      READ: begin
        // SRAM returns data within the strobe cycle, so capture at this edge.
        out_data_nxt  = sram_read_data;
        out_valid_nxt = 1'b1;
        out_last_nxt  = (remaining == REM_ONE);
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
          if (remaining == REM_ONE) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = remaining - REM_ONE;
            cur_addr_nxt  = cur_addr + 1'b1;  // wraps modulo SRAM depth
            state_nxt     = READ;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign sram_read_enable = (state == READ);

  // Reads own the bus only during READ; writes fill every other cycle.
  assign bus_free          = !sram_read_enable;
  assign wr_ack            = wr_req && bus_free && !rst;
  assign sram_write_enable = wr_ack;
  assign sram_address      = wr_ack ? wr_addr : cur_addr;
  assign sram_write_data   = wr_ack ? wr_data : '0;

endmodule

// File: tb/tb_sram_block_fetcher.sv
module tb_sram_block_fetcher;
  localparam int AW    = 6;
  localparam int DW    = 128;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          sram_read_enable, sram_write_enable;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data, sram_read_data;

  always #5 clk = ~clk;

  sram_block_fetcher #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .sram_read_enable(sram_read_enable),
    .sram_write_enable(sram_write_enable), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  // SRAM model (driven by DUT strobes) and the bench's own expected contents.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (sram_write_enable) mem[sram_address] = sram_write_data;
  end
  assign sram_read_data = sram_read_enable ? mem[sram_address] : '0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [AW-1:0] rd_log[$];
  int            tests = 0;
  int            fails = 0;
  int            hs_cnt = 0;
  int            done_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe rules, stall stability, scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_read_enable || sram_write_enable)
        chk("strobe_exclusive", DW'(sram_read_enable & sram_write_enable), '0);
      else
        chk("idle_write_data", sram_write_data, '0);
      if (sram_read_enable) rd_log.push_back(sram_address);
      if (done) done_cnt++;
      if (out_valid && prev_stall) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_last", DW'(out_last), DW'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", out_data);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_last", DW'(out_last), DW'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Drives one burst; checks done timing, read address order and beat count.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] cnt,
                           input int stall_beat, input int stall_len, input int exp_done);
    int k, stalled, hs0, dc0;
    bit seen;
    rd_log.delete();
    for (int i = 0; i < int'(cnt); i++)
      sb.push_back('{data: ref_mem[(int'(base) + i) % DEPTH], last: (i == int'(cnt) - 1)});
    hs0 = hs_cnt;
    dc0 = done_cnt;
    stalled = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = cnt; out_ready = 1'b1;
    @(posedge clk); #1;  // start sampled at this edge (E0)
    start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k <= exp_done + 20) begin
      @(negedge clk);
      if (k == 0) chk("busy_after_start", DW'(busy), DW'(1));
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (out_valid && (hs_cnt - hs0) == stall_beat && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
        end
        k++;
      end
    end
    chk("done_cycle", DW'(k), DW'(exp_done));
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done", DW'(busy), '0);
    chk("done_one_cycle", DW'(done), '0);
    chk("done_pulses", DW'(done_cnt - dc0), DW'(1));
    chk("read_count", DW'(rd_log.size()), DW'(cnt));
    for (int i = 0; i < rd_log.size() && i < int'(cnt); i++)
      chk("read_addr", DW'(rd_log[i]), DW'((int'(base) + i) % DEPTH));
    chk("sb_drained", DW'(sb.size()), '0);
    sb.delete();
  endtask

  // Caller aligns to just after a rising edge; latency counts cycles to wr_ack.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_lat);
    int k;
    bit seen;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (wr_ack) begin
        seen = 1'b1;
        chk("wr_bus_addr", DW'(sram_address), DW'(a));
        chk("wr_bus_data", sram_write_data, d);
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("wr_latency", DW'(k), DW'(exp_lat));
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            stall_beat;
    int            stall_len;
    int            exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, dc0;
    vecs[0] = '{6'd22, 7'd1,  -1, 0, 2};    // single entry after writes
    vecs[1] = '{6'd0,  7'd3,   1, 5, 11};   // stall 5 cycles on beat 1
    vecs[2] = '{6'd62, 7'd4,  -1, 0, 8};    // address wrap
    vecs[3] = '{6'd0,  7'd0,  -1, 0, 0};    // empty burst
    vecs[4] = '{6'd33, 7'd5,   0, 2, 12};   // stall on first beat
    vecs[5] = '{6'd7,  7'd64, -1, 0, 128};  // full-depth burst

    for (int a = 0; a < DEPTH; a++) begin
      mem[a]     = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[a] = mem[a];
    end

    #12;
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_last", DW'(out_last), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_read_en", DW'(sram_read_enable), '0);
    chk("rst_write_en", DW'(sram_write_enable), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Writes from IDLE are acked in the request cycle.
    @(posedge clk); #1;
    ref_mem[0] = 128'haabbccddeeff00112233445566778899;
    do_write(6'd0, 128'haabbccddeeff00112233445566778899, 0);
    ref_mem[6'h16] = 128'haaccddbbeeff00112233445566778899;
    do_write(6'h16, 128'haaccddbbeeff00112233445566778899, 0);

    for (int v = 0; v < 6; v++)
      run_burst(vecs[v].base, vecs[v].cnt, vecs[v].stall_beat, vecs[v].stall_len, vecs[v].exp_done);

    // Write raised during the first READ of a burst over 4..6: acked one cycle later,
    // lands before address 5 is read.
    ref_mem[5] = '1;
    fork
      run_burst(6'd4, 7'd3, -1, 0, 6);
      begin
        @(posedge clk);
        @(posedge clk); #1;
        do_write(6'd5, '1, 1);
      end
    join

    // A second start while busy must be ignored.
    fork
      run_burst(6'd10, 7'd2, -1, 0, 4);
      begin
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 6'd20; count = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join

    // Reset asserted while holding the first beat of an 8-entry burst.
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd0; count = 7'd8; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_reached", DW'(out_valid), DW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", DW'(busy), '0);
    chk("mid_rst_done", DW'(done), '0);
    chk("mid_rst_out_valid", DW'(out_valid), '0);
    chk("mid_rst_out_last", DW'(out_last), '0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_read_en", DW'(sram_read_enable), '0);
    chk("mid_rst_write_en", DW'(sram_write_enable), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_rst", DW'(done_cnt - dc0), '0);
    chk("idle_after_rst", DW'(busy), '0);
    run_burst(6'd0, 7'd8, -1, 0, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
    $fatal(1);
  end

endmodule
